// File: rtl/conf_regs.sv
// Configuration register block: scratch, LED, synchronized switches, free-running counter.
// Optional compare timer (TIMER_CMP / TIMER_CTRL / timer_irq) is built only when CONF_TIMER_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module conf_regs #(
   parameter int ADDR_BITS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             conf_en,
   input  logic [3:0]       conf_wen,
   input  logic [`XLEN-1:0] conf_addr,
   input  logic [`XLEN-1:0] conf_wdata,
   output logic [`XLEN-1:0] conf_rdata,
   input  logic [15:0]      switch_in,
   output logic [15:0]      led_out,
   output logic             timer_irq
);
   localparam logic [ADDR_BITS-1:0] OFF_SCRATCH = ADDR_BITS'(8'h00);
   localparam logic [ADDR_BITS-1:0] OFF_LED     = ADDR_BITS'(8'h04);
   localparam logic [ADDR_BITS-1:0] OFF_SWITCH  = ADDR_BITS'(8'h08);
   localparam logic [ADDR_BITS-1:0] OFF_COUNTER = ADDR_BITS'(8'h0C);
`ifdef CONF_TIMER_EN
   localparam logic [ADDR_BITS-1:0] OFF_TCMP    = ADDR_BITS'(8'h10);
   localparam logic [ADDR_BITS-1:0] OFF_TCTRL   = ADDR_BITS'(8'h14);

   logic [31:0] timer_cmp;
   logic        timer_en;
   logic        timer_pend;
   logic        timer_hit;
   logic        timer_clr;
`endif

   logic [ADDR_BITS-1:0] offset;
   logic                 wr;
   logic                 rd;
   logic [31:0]          wdata;
   logic [31:0]          rd_val;
   logic [31:0]          scratch;
   logic [31:0]          counter;
   logic [15:0]          led;
   logic [15:0]          sw_meta;
   logic [15:0]          sw_sync;
   logic                 unused_addr;

   // Upper address bits belong to the bridge's base decode; [1:0] are byte offsets within a word.
   assign offset      = {conf_addr[ADDR_BITS-1:2], 2'b00};
   assign unused_addr = ^{conf_addr[`XLEN-1:ADDR_BITS], conf_addr[1:0]};
   assign wr          = conf_en && (conf_wen != 4'b0000);
   assign rd          = conf_en && (conf_wen == 4'b0000);
   assign wdata       = conf_wdata[31:0];
   assign led_out     = led;

   function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                         input logic [3:0] be);
      for (int i = 0; i < 4; i++)
         merge[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
   endfunction

   always_comb begin
      // NOTE: default first so every path assigns rd_val; otherwise a latch is inferred.
      rd_val = 32'h0;
      case (offset)
         OFF_SCRATCH: rd_val = scratch;
         OFF_LED:     rd_val = {16'h0, led};
         OFF_SWITCH:  rd_val = {16'h0, sw_sync};
         OFF_COUNTER: rd_val = counter;
`ifdef CONF_TIMER_EN
         OFF_TCMP:    rd_val = timer_cmp;
         OFF_TCTRL:   rd_val = {30'h0, timer_pend, timer_en};
`endif
         default:     rd_val = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         scratch    <= 32'h0;
         led        <= 16'h0;
         counter    <= 32'h0;
         sw_meta    <= 16'h0;
         sw_sync    <= 16'h0;
         conf_rdata <= '0;
      end else begin
         counter <= counter + 32'd1;
         sw_meta <= switch_in;
         sw_sync <= sw_meta;
         if (wr && offset == OFF_SCRATCH)
            scratch <= merge(scratch, wdata, conf_wen);
         if (wr && offset == OFF_LED) begin
            if (conf_wen[0]) led[7:0]  <= wdata[7:0];
            if (conf_wen[1]) led[15:8] <= wdata[15:8];
         end
         if (rd)
            conf_rdata <= `XLEN'(rd_val);
      end
   end

`ifdef CONF_TIMER_EN
   // Compare uses the current (pre-write) TIMER_CMP; a set in the same cycle beats a W1C clear.
   assign timer_hit = timer_en && (counter == timer_cmp);
   assign timer_clr = wr && (offset == OFF_TCTRL) && conf_wen[0] && wdata[1];
   assign timer_irq = timer_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_cmp  <= 32'h0;
         timer_en   <= 1'b0;
         timer_pend <= 1'b0;
      end else begin
         if (wr && offset == OFF_TCMP)
            timer_cmp <= merge(timer_cmp, wdata, conf_wen);
         if (wr && offset == OFF_TCTRL && conf_wen[0])
            timer_en <= wdata[0];
         if (timer_hit)
            timer_pend <= 1'b1;
         else if (timer_clr)
            timer_pend <= 1'b0;
      end
   end
`else
   assign timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_conf_regs.sv
// Bench for conf_regs: directed register-map checks followed by random traffic against a map-level model.
// Define CONF_TIMER_EN for both the DUT and this bench to exercise the timer.
`ifndef XLEN
`define XLEN 32
`endif

module tb_conf_regs;
   logic             clk = 1'b0;
   logic             reset;
   logic             conf_en;
   logic [3:0]       conf_wen;
   logic [`XLEN-1:0] conf_addr;
   logic [`XLEN-1:0] conf_wdata;
   logic [`XLEN-1:0] conf_rdata;
   logic [15:0]      switch_in;
   logic [15:0]      led_out;
   logic             timer_irq;

   always #5 clk = ~clk;

   conf_regs #(.ADDR_BITS(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .conf_en    (conf_en),
      .conf_wen   (conf_wen),
      .conf_addr  (conf_addr),
      .conf_wdata (conf_wdata),
      .conf_rdata (conf_rdata),
      .switch_in  (switch_in),
      .led_out    (led_out),
      .timer_irq  (timer_irq)
   );

`ifdef CONF_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the register map as plain variables, switch synchronizer as a 2-deep queue.
   logic [31:0] m_scratch, m_cnt, m_cmp, m_rdata;
   logic [15:0] m_led;
   logic        m_en, m_pend;
   logic [15:0] m_sw[$];

   function automatic logic [31:0] m_read(input logic [31:0] addr);
      case (addr[15:0] & 16'hFFFC)
         16'h0000: return m_scratch;
         16'h0004: return {16'h0, m_led};
         16'h0008: return {16'h0, m_sw[0]};
         16'h000C: return m_cnt;
         16'h0010: return TIMER ? m_cmp : 32'h0;
         16'h0014: return TIMER ? {30'h0, m_pend, m_en} : 32'h0;
         default:  return 32'h0;
      endcase
   endfunction

   task automatic model_edge();
      logic [31:0] mask, rv, t;
      logic        is_wr, hit, clr;
      if (reset) begin
         m_scratch = 32'h0; m_cnt = 32'h0; m_cmp = 32'h0; m_rdata = 32'h0;
         m_led = 16'h0; m_en = 1'b0; m_pend = 1'b0;
         m_sw = '{16'h0, 16'h0};
         return;
      end
      rv    = m_read(conf_addr);
      mask  = {{8{conf_wen[3]}}, {8{conf_wen[2]}}, {8{conf_wen[1]}}, {8{conf_wen[0]}}};
      is_wr = conf_en && (conf_wen != 4'h0);
      hit   = TIMER && m_en && (m_cnt == m_cmp);
      clr   = TIMER && is_wr && ((conf_addr[15:0] & 16'hFFFC) == 16'h0014)
              && conf_wen[0] && conf_wdata[1];
      if (conf_en && conf_wen == 4'h0)
         m_rdata = rv;
      if (is_wr) begin
         case (conf_addr[15:0] & 16'hFFFC)
            16'h0000: m_scratch = (m_scratch & ~mask) | (conf_wdata & mask);
            16'h0004: begin
               t     = ({16'h0, m_led} & ~mask) | (conf_wdata & mask);
               m_led = t[15:0];
            end
            16'h0010: if (TIMER) m_cmp = (m_cmp & ~mask) | (conf_wdata & mask);
            16'h0014: if (TIMER && conf_wen[0]) m_en = conf_wdata[0];
            default: ;
         endcase
      end
      m_pend = hit | (m_pend & ~clr);
      m_cnt  = m_cnt + 32'd1;
      void'(m_sw.pop_front());
      m_sw.push_back(switch_in);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      reset = rst; conf_en = en; conf_wen = wen; conf_addr = addr; conf_wdata = wd;
      @(posedge clk);
      model_edge();
      #1;
      check("rdata", conf_rdata, m_rdata);
      check("led_out", {16'h0, led_out}, {16'h0, m_led});
      check("timer_irq", {31'h0, timer_irq}, {31'h0, m_pend});
   endtask

   task automatic do_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wen);
      step(1'b0, 1'b1, wen, addr, wd);
   endtask

   task automatic do_rd(input logic [31:0] addr);
      step(1'b0, 1'b1, 4'h0, addr, 32'h0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   logic [31:0] r1, c;

   initial begin
      reset = 1'b1; conf_en = 1'b0; conf_wen = 4'h0; conf_addr = '0; conf_wdata = '0;
      switch_in = 16'h0;
      m_sw = '{16'h0, 16'h0};

      step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
      check("reset_rdata", conf_rdata, 32'h0);
      check("reset_led", {16'h0, led_out}, 32'h0);
      check("reset_irq", {31'h0, timer_irq}, 32'h0);

      // Byte-lane merge on SCRATCH, upper address bits ignored
      do_wr(32'h0, 32'hDEADBEEF, 4'b1111);
      do_wr(32'h0, 32'h00000011, 4'b0001);
      do_rd(32'h0);
      check("scratch_merge", conf_rdata, 32'hDEADBE11);
      do_rd(32'hABCD_0000);
      check("scratch_alias", conf_rdata, 32'hDEADBE11);
      idle();
      check("rdata_hold", conf_rdata, 32'hDEADBE11);

      do_wr(32'h4, 32'hFFFF_A5A5, 4'b1111);
      check("led_drive", {16'h0, led_out}, 32'h0000_A5A5);
      do_rd(32'h4);
      check("led_read", conf_rdata, 32'h0000_A5A5);

      // Unmapped and read-only offsets
      do_wr(32'h18, 32'h1234_5678, 4'hF);
      do_wr(32'h8, 32'hFFFF_FFFF, 4'hF);
      do_rd(32'h18);
      check("unmapped_read", conf_rdata, 32'h0);

      // Switch synchronizer latency
      switch_in = 16'h1234;
      do_rd(32'h8);
      check("switch_0cyc", conf_rdata, 32'h0);
      do_rd(32'h8);
      check("switch_1cyc", conf_rdata, 32'h0);
      do_rd(32'h8);
      check("switch_2cyc", conf_rdata, 32'h0000_1234);

      do_rd(32'hC);
      r1 = conf_rdata;
      do_rd(32'hC);
      check("counter_b2b", conf_rdata - r1, 32'd1);

`ifdef CONF_TIMER_EN
      do_wr(32'h10, 32'd50, 4'hF);
      do_wr(32'h14, 32'h1, 4'h1);
      for (int i = 0; i < 100 && m_cnt != 32'd50; i++) idle();
      check("irq_before_match", {31'h0, timer_irq}, 32'h0);
      idle();
      check("irq_after_match", {31'h0, timer_irq}, 32'h1);

      c = m_cnt;
      do_wr(32'h10, c + 32'd2, 4'hF);
      idle();
      do_wr(32'h14, 32'h3, 4'h1);
      check("w1c_loses_to_set", {31'h0, timer_irq}, 32'h1);
      do_wr(32'h14, 32'h3, 4'h1);
      check("w1c_clears", {31'h0, timer_irq}, 32'h0);

      do_wr(32'h10, m_cnt, 4'hF);
      check("cmp_uses_old", {31'h0, timer_irq}, 32'h0);

      do_wr(32'h10, m_cnt + 32'd1, 4'hF);
      idle();
      check("irq_set_again", {31'h0, timer_irq}, 32'h1);
      do_wr(32'h14, 32'h0, 4'h1);
      check("en_clear_keeps_pend", {31'h0, timer_irq}, 32'h1);
`else
      do_wr(32'h10, 32'hFFFF_FFFF, 4'hF);
      do_wr(32'h14, 32'h3, 4'h1);
      do_rd(32'h10);
      check("no_timer_cmp", conf_rdata, 32'h0);
      do_rd(32'h14);
      check("no_timer_ctrl", conf_rdata, 32'h0);
      check("no_timer_irq", {31'h0, timer_irq}, 32'h0);
`endif

      // Reset in the middle of a read stream
      do_rd(32'h0);
      step(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
      check("mid_reset_rdata", conf_rdata, 32'h0);
      check("mid_reset_led", {16'h0, led_out}, 32'h0);
      check("mid_reset_irq", {31'h0, timer_irq}, 32'h0);
      do_rd(32'hC);
      check("counter_restart", conf_rdata, 32'h0);

      // Random traffic; CMP writes are biased near the counter so the timer actually fires
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, d;
         logic [3:0]  w;
         a = 32'(4 * $urandom_range(0, 8)) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
         d = $urandom;
         if (a[15:2] == 14'h4 && $urandom_range(0, 1) == 0) d = m_cnt + 32'($urandom_range(0, 6));
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 7) == 0) switch_in = 16'($urandom);
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, w, a, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conf_regs.md
CONF_REGS -- requirements
Module: conf_regs

Interface
REQ-001 Parameter: ADDR_BITS, 16, number of low conf_addr bits decoded; upper bits ignored (the upstream bridge performs base-address selection).
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: conf_en, input, 1, access request this cycle.
REQ-005 Port: conf_wen, input, 4, byte write enables; nonzero means write, zero means read.
REQ-006 Port: conf_addr, input, `XLEN, byte address; word-aligned, so bits [1:0] are ignored.
REQ-007 Port: conf_wdata, input, `XLEN, write data.
REQ-008 Port: conf_rdata, output, `XLEN, registered read data.
REQ-009 Port: switch_in, input, 16, asynchronous board switches.
REQ-010 Port: led_out, output, 16, LED drive; equals LED register bits [15:0].
REQ-011 Port: timer_irq, output, 1, timer interrupt; level signal, equals the pending bit.

Function
REQ-012 Register map (offset = conf_addr[ADDR_BITS-1:0]):
- 0x00 SCRATCH: RW, 32 bits.
- 0x04 LED: RW, bits [15:0]; bits [31:16] read 0.
- 0x08 SWITCH: RO, synchronized switch_in in bits [15:0].
- 0x0C COUNTER: RO, 32-bit free-running counter.
- 0x10 TIMER_CMP: RW, 32 bits.
- 0x14 TIMER_CTRL: bit0 EN (RW), bit1 PEND (write-1-to-clear); other bits read 0.
REQ-013 Write: occurs when conf_en=1 and conf_wen!=0; byte lane i updates only if conf_wen[i]=1; the register takes the new value at the next edge.
REQ-014 Read: occurs when conf_en=1 and conf_wen=0; conf_rdata presents the addressed value, sampled in the request cycle, exactly one cycle later.
REQ-015 conf_rdata holds its last value in cycles with no read request.
REQ-016 Reads of unmapped offsets return 0; writes to unmapped or RO offsets have no effect and no side effects.
REQ-017 Back-to-back reads every cycle are supported with no stall; each result appears one cycle after its request.
REQ-018 switch_in passes through a 2-flop synchronizer before reaching SWITCH; SWITCH therefore reflects switch_in after 2 cycles.
REQ-019 COUNTER increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
REQ-020 A COUNTER read returns the value present in the request cycle, not the incremented value.
REQ-021 PEND sets in any cycle where EN=1 and COUNTER==TIMER_CMP.
REQ-022 Writing 1 to TIMER_CTRL bit1 (with conf_wen[0]=1) clears PEND; writing 0 to bit1 leaves PEND unchanged.
REQ-023 If a set condition and a clear write occur in the same cycle, set wins and PEND remains 1.
REQ-024 Clearing EN does not clear PEND.
REQ-025 A write and a set condition affecting TIMER_CMP in the same cycle use the old TIMER_CMP value for the compare.

Reset
REQ-026 While reset=1, all registers go to 0 at the clock edge: SCRATCH, LED, COUNTER, TIMER_CMP, EN, PEND, both synchronizer stages, and conf_rdata.
REQ-027 Outputs after reset: led_out=0, timer_irq=0, conf_rdata=0.
REQ-028 Any access presented during reset is discarded; no read response follows.
REQ-029 COUNTER restarts at 0 on the first cycle after reset deasserts.

Configuration
REQ-030 Macro CONF_TIMER_EN controls the timer:
- Defined: TIMER_CMP, TIMER_CTRL, and timer_irq behave as in REQ-021 to REQ-025.
- Undefined: offsets 0x10 and 0x14 behave as unmapped (read 0, writes ignored), timer_irq is tied to 0, and no timer state is synthesized.
- COUNTER is present in both cases.

Verification
REQ-031 Write SCRATCH 0xDEADBEEF with conf_wen=4'b1111, then write 0x00000011 with conf_wen=4'b0001, then read -> conf_rdata=0xDEADBE11 one cycle after the read request.
REQ-032 Write LED 0xFFFF_A5A5 -> led_out=0xA5A5; reading LED returns 0x0000_A5A5.
REQ-033 Drive switch_in=0x1234 -> SWITCH reads 0x1234 only once 2 cycles have elapsed; a read issued earlier returns the prior value.
REQ-034 (CONF_TIMER_EN defined) Write TIMER_CMP=50 and EN=1 -> timer_irq rises the cycle after COUNTER==50. A W1C write on the same cycle as a match leaves timer_irq=1; a W1C write on a later non-match cycle drops timer_irq to 0.
REQ-035 Issue back-to-back reads of COUNTER at consecutive cycles -> returned values differ by exactly 1. Force COUNTER to 0xFFFF_FFFF -> the next cycle it reads 0.
REQ-036 Assert reset mid-stream of reads with pending IRQ -> next cycle all outputs 0. (CONF_TIMER_EN undefined) Read 0x14 -> 0 and timer_irq stays 0.
